demux1to16_stream: RTL and testbench
====================================

// Module: demux1to16_stream
// PURPOSE
//   Registered 1-to-NUM_OUT stream demultiplexer; the receive-side counterpart of the mux16_1 tree.
//   Steers each accepted input word to exactly one of NUM_OUT output channels selected by in_sel.
//   Uses valid/ready handshakes on both sides. Sits between a single producer and NUM_OUT consumers.
// PARAMETERS
//   DATA_W   8    width of the data word
//   NUM_OUT  16   number of output channels (2..16)
//   SEL_W    4    width of in_sel; must satisfy 2**SEL_W >= NUM_OUT
// PORTS
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous reset, active-low
//   in_valid   in   1              input word present
//   in_ready   out  1              block can accept this cycle
//   in_data    in   DATA_W         input word
//   in_sel     in   SEL_W          destination channel index
//   out_valid  out  NUM_OUT        one-hot valid; bit k means channel k holds a word
//   out_ready  in   NUM_OUT        per-channel consumer ready
//   out_data   out  DATA_W         shared data bus, meaningful only for the asserted valid bit
//   sel_err    out  1              one-cycle pulse when an out-of-range in_sel word is dropped
//   err_cnt    out  8              count of dropped words, saturates at 255
// BEHAVIOUR
//   - Reset (async assert, sync release): out_valid=0, out_data=0, sel_err=0, err_cnt=0, FSM=EMPTY.
//   - Transfer: in = in_valid & in_ready. Out channel k = out_valid[k] & out_ready[k].
//   - Latency: a word accepted in cycle t appears on out_valid[in_sel] in cycle t+1. Throughput is 1 word/cycle.
//   - out_valid has at most one bit set. out_data and out_valid hold stable until the transfer completes.
//   - Head register (data, dest): in_ready = !head_full | out_ready[dest], which is combinational from out_ready.
//   - Simultaneous drain and accept in the same cycle: the head is replaced with no bubble.
//   - in_sel >= NUM_OUT: the word is accepted (in_ready is 1 for it when the head is empty or draining) and discarded.
//       sel_err pulses in cycle t+1.
//       err_cnt increments, holding at 255.
//       No out_valid is raised.
//   - in_valid=0 never changes state. out_ready bits for idle channels are ignored.
//   - Reset mid-transfer: any held word is lost. No output is asserted until a new word is accepted.
// CONFIGURATION
//   Macro DEMUX_SKID_EN.
//   - Defined: adds a skid register and a 3-state FSM.
//       EMPTY -in-> ONE
//       ONE -in & !drain-> TWO
//       ONE -drain & !in-> EMPTY
//       TWO -drain-> ONE
//   - Defined, continued: in_ready = (state != TWO), a pure register output with no out_ready->in_ready path.
//   - Defined, continued: order is preserved, with the skid word moving to the head on drain. Latency remains 1 cycle.
//   - Undefined: single head register, with the in_ready equation above. FSM states are EMPTY and ONE only.
// STRUCTURE
//   - Package demux_pkg:
//       typedef enum {ST_EMPTY, ST_ONE, ST_TWO} demux_state_t
//       localparam ERR_CNT_MAX = 8'd255
//   - Sub-module demux_slot: one register of {data, dest} with load/clear.
//       Instantiated once, or twice under DEMUX_SKID_EN.
//   - Top level holds the FSM, one-hot dest decode, and error counter.
// TESTING
//   1. Reset with in_valid=1: out_valid==0, err_cnt==0 while rst_n=0. First accept occurs only after release.
//   2. in_data=8'hA5, in_sel=4'd9, out_ready=all 1.
//        Next cycle: out_valid==16'h0200 and out_data==8'hA5. It is cleared the cycle after.
//   3. Back-to-back stream:
//        in_sel = 0,1,...,15 with data = sel*8'h11, out_ready=all 1, continuous.
//        One word per cycle; out_valid walks 16'h0001 to 16'h8000; no bubbles.
//   4. Backpressure: hold out_ready[3]=0 with the head on channel 3.
//        Without macro: in_ready==0 and data is held stable.
//        With DEMUX_SKID_EN: one extra word is accepted, then in_ready==0. Release drains both in order.
//   5. NUM_OUT=10, in_sel=4'd12: sel_err pulses once and err_cnt==1. No out_valid is raised.
//        After 300 such words, err_cnt==255.
//   6. Assert rst_n=0 while out_valid==16'h0010 and out_ready=0: out_valid==0 immediately (async).

Source files
------------

// File: rtl/demux1to16_stream_pkg.sv
// Shared types and constants for the demux1to16_stream stream demultiplexer.
// The optional skid stage (macro DEMUX_SKID_EN) uses ST_TWO; the default build
// only ever visits ST_EMPTY and ST_ONE.
package demux_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } demux_state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/demux1to16_stream_if.sv
// Handshake bundle between one producer, the demultiplexer and NUM_OUT consumers.
// The slave modport is the demultiplexer's view; master is the environment's.
interface demux1to16_stream_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 16,
  parameter int SEL_W   = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [SEL_W-1:0]   in_sel;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               sel_err;
  logic [7:0]         err_cnt;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, sel_err, err_cnt
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, sel_err, err_cnt
  );
endinterface

// File: rtl/demux1to16_stream_slot.sv
// One {data, dest} holding register. Load takes priority over clear; clear
// zeroes the slot so an empty head drives a quiet data bus.
module demux_slot #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [SEL_W-1:0]  d_dest,
  output logic [DATA_W-1:0] q_data,
  output logic [SEL_W-1:0]  q_dest
);

  // Slot contents: load new word, clear on empty, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_data <= '0;
      q_dest <= '0;
    end else if (load) begin
      q_data <= d_data;
      q_dest <= d_dest;
    end else if (clear) begin
      q_data <= '0;
      q_dest <= '0;
    end
  end

endmodule

// File: rtl/demux1to16_stream.sv
// Registered 1-to-NUM_OUT stream demultiplexer. Each accepted word is steered
// to the channel named by in_sel one cycle later; words with an out-of-range
// in_sel are swallowed, flagged on sel_err and counted in err_cnt.
// Optional macro DEMUX_SKID_EN adds a skid slot so in_ready is a pure register
// output (no out_ready -> in_ready combinational path).
module demux1to16_stream
  import demux_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 16,
  parameter int SEL_W   = 4
) (
  input logic               clk,
  input logic               rst_n,
  demux1to16_stream_if.slave bus
);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 8'd1;
  endfunction

  demux_state_t      state, state_nx;
  logic              sel_ok, acc, push, drain;
  logic              head_load, head_clr;
  logic [DATA_W-1:0] head_data, head_d_data;
  logic [SEL_W-1:0]  head_dest, head_d_dest;
  logic              sel_err_q;
  logic [7:0]        err_cnt_q;

  assign sel_ok = 32'(bus.in_sel) < NUM_OUT;
  assign acc    = bus.in_valid & bus.in_ready;
  assign push   = acc & sel_ok;

  // A word can only leave through the single asserted valid bit.
  assign bus.out_valid = (state != ST_EMPTY) ? (NUM_OUT'(1) << head_dest) : '0;
  assign bus.out_data  = head_data;
  assign drain         = |(bus.out_valid & bus.out_ready);
  assign bus.sel_err   = sel_err_q;
  assign bus.err_cnt   = err_cnt_q;

`ifdef DEMUX_SKID_EN
  logic              skid_load, head_from_skid;
  logic [DATA_W-1:0] skid_data;
  logic [SEL_W-1:0]  skid_dest;

  assign bus.in_ready = (state != ST_TWO);
  assign head_d_data  = head_from_skid ? skid_data : bus.in_data;
  assign head_d_dest  = head_from_skid ? skid_dest : bus.in_sel;

  demux_slot #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skid_load),
    .clear  (1'b0),
    .d_data (bus.in_data),
    .d_dest (bus.in_sel),
    .q_data (skid_data),
    .q_dest (skid_dest)
  );
`else
  assign bus.in_ready = (state == ST_EMPTY) | drain;
  assign head_d_data  = bus.in_data;
  assign head_d_dest  = bus.in_sel;
`endif

  demux_slot #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_head (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (head_load),
    .clear  (head_clr),
    .d_data (head_d_data),
    .d_dest (head_d_dest),
    .q_data (head_data),
    .q_dest (head_dest)
  );

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nx;
  end

  // Next occupancy and slot steering; simultaneous drain and push refill the head with no bubble.
  always_comb begin
    state_nx  = state;
    head_load = 1'b0;
    head_clr  = 1'b0;
`ifdef DEMUX_SKID_EN
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
`endif
    unique case (state)
      ST_EMPTY: begin
        if (push) begin
          state_nx  = ST_ONE;
          head_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (push && drain) begin
          head_load = 1'b1;
        end else if (push) begin
`ifdef DEMUX_SKID_EN
          state_nx  = ST_TWO;
          skid_load = 1'b1;
`else
          head_load = 1'b1;
`endif
        end else if (drain) begin
          state_nx = ST_EMPTY;
          head_clr = 1'b1;
        end
      end
`ifdef DEMUX_SKID_EN
      ST_TWO: begin
        if (drain) begin
          state_nx       = ST_ONE;
          head_load      = 1'b1;
          head_from_skid = 1'b1;
        end
      end
`endif
      default: state_nx = ST_EMPTY;
    endcase
  end

  // Dropped-word pulse and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      sel_err_q <= acc & ~sel_ok;
      if (acc && !sel_ok) err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

endmodule

// File: tb/tb_demux1to16_stream.sv
// Bench for demux1to16_stream: a 16-channel instance checked every cycle against
// a queue model, plus a 10-channel instance for out-of-range select handling.
// Honours DEMUX_SKID_EN when compiled with it.
module tb_demux1to16_stream;

  typedef struct {
    logic [7:0] data;
    logic [3:0] dest;
  } word_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  demux1to16_stream_if #(.DATA_W(8), .NUM_OUT(16), .SEL_W(4)) a_if();
  demux1to16_stream_if #(.DATA_W(8), .NUM_OUT(10), .SEL_W(4)) b_if();

  demux1to16_stream #(.DATA_W(8), .NUM_OUT(16), .SEL_W(4)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (a_if.slave)
  );
  demux1to16_stream #(.DATA_W(8), .NUM_OUT(10), .SEL_W(4)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the 16-channel instance: FIFO of words waiting to be delivered.
  word_t q[$];
  always @(negedge clk) begin
    logic [15:0] ev;
    bit          er, ac, dr;
    word_t       w;
    if (!rst_n) q.delete();
    ev = (q.size() > 0) ? (16'd1 << q[0].dest) : 16'd0;
`ifdef DEMUX_SKID_EN
    er = (q.size() < 2);
`else
    er = (q.size() == 0) || a_if.out_ready[q[0].dest];
`endif
    chk("cmp_out_valid", 32'(a_if.out_valid), 32'(ev));
    if (q.size() > 0) chk("cmp_out_data", 32'(a_if.out_data), 32'(q[0].data));
    chk("cmp_in_ready", 32'(a_if.in_ready), 32'(er));
    chk("cmp_sel_err", 32'(a_if.sel_err), 32'd0);
    chk("cmp_err_cnt", 32'(a_if.err_cnt), 32'd0);
    if (rst_n) begin
      ac = a_if.in_valid && er;
      dr = (q.size() > 0) && a_if.out_ready[q[0].dest];
      if (dr) void'(q.pop_front());
      if (ac) begin
        w.data = a_if.in_data;
        w.dest = a_if.in_sel;
        q.push_back(w);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    a_if.in_valid = 1'b1; a_if.in_data = 8'h5A; a_if.in_sel = 4'd0; a_if.out_ready = '1;
    b_if.in_valid = 1'b0; b_if.in_data = 8'h00; b_if.in_sel = 4'd0; b_if.out_ready = '1;

    // Reset held with a word offered.
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(a_if.out_valid), 32'h0);
      chk("rst_err_cnt", 32'(a_if.err_cnt), 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_no_word_yet", 32'(a_if.out_valid), 32'h0);
    cyc();
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("rel_first_word", 32'(a_if.out_valid), 32'h0001);
    repeat (2) cyc();

    // Single word to channel 9.
    a_if.in_valid = 1'b1; a_if.in_data = 8'hA5; a_if.in_sel = 4'd9;
    cyc();
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("t2_out_valid", 32'(a_if.out_valid), 32'h0200);
    chk("t2_out_data", 32'(a_if.out_data), 32'hA5);
    cyc();
    @(negedge clk);
    chk("t2_cleared", 32'(a_if.out_valid), 32'h0);
    cyc();

    // Back-to-back walk over all channels.
    for (int s = 0; s < 16; s++) begin
      a_if.in_valid = 1'b1; a_if.in_sel = 4'(s); a_if.in_data = 8'(s * 17);
      @(negedge clk);
      if (s > 0) begin
        chk("t3_walk_valid", 32'(a_if.out_valid), 32'h1 << (s - 1));
        chk("t3_walk_data", 32'(a_if.out_data), 32'((s - 1) * 17));
      end
      cyc();
    end
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("t3_walk_last", 32'(a_if.out_valid), 32'h8000);
    chk("t3_walk_last_data", 32'(a_if.out_data), 32'hFF);
    cyc();

    // Backpressure on channel 3.
    a_if.in_valid = 1'b1; a_if.in_sel = 4'd3; a_if.in_data = 8'h3C;
    cyc();
    a_if.out_ready[3] = 1'b0;
    a_if.in_sel = 4'd5; a_if.in_data = 8'h77;
`ifdef DEMUX_SKID_EN
    @(negedge clk);
    chk("t4_skid_ready", 32'(a_if.in_ready), 32'h1);
    cyc();
    a_if.in_sel = 4'd6; a_if.in_data = 8'h99;
`endif
    repeat (3) begin
      @(negedge clk);
      chk("t4_bp_ready", 32'(a_if.in_ready), 32'h0);
      chk("t4_bp_valid", 32'(a_if.out_valid), 32'h0008);
      chk("t4_bp_data", 32'(a_if.out_data), 32'h3C);
      cyc();
    end
    a_if.out_ready = '1;
`ifdef DEMUX_SKID_EN
    cyc();
    @(negedge clk);
    chk("t4_drain1_valid", 32'(a_if.out_valid), 32'h0020);
    chk("t4_drain1_data", 32'(a_if.out_data), 32'h77);
    cyc();
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_drain2_valid", 32'(a_if.out_valid), 32'h0040);
    chk("t4_drain2_data", 32'(a_if.out_data), 32'h99);
`else
    @(negedge clk);
    chk("t4_release_ready", 32'(a_if.in_ready), 32'h1);
    cyc();
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_drain_valid", 32'(a_if.out_valid), 32'h0020);
    chk("t4_drain_data", 32'(a_if.out_data), 32'h77);
`endif
    repeat (2) cyc();

    // Out-of-range select on the 10-channel instance.
    b_if.in_valid = 1'b1; b_if.in_sel = 4'd12; b_if.in_data = 8'h42;
    @(negedge clk);
    chk("t5_bad_ready", 32'(b_if.in_ready), 32'h1);
    cyc();
    b_if.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_sel_err", 32'(b_if.sel_err), 32'h1);
    chk("t5_err_cnt1", 32'(b_if.err_cnt), 32'h1);
    chk("t5_no_valid", 32'(b_if.out_valid), 32'h0);
    cyc();
    @(negedge clk);
    chk("t5_sel_err_pulse", 32'(b_if.sel_err), 32'h0);
    chk("t5_err_cnt_hold", 32'(b_if.err_cnt), 32'h1);
    cyc();
    b_if.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      b_if.in_sel = 4'($urandom_range(10, 15));
      b_if.in_data = 8'($urandom);
      cyc();
    end
    b_if.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_err_cnt_sat", 32'(b_if.err_cnt), 32'd255);
    chk("t5_sat_no_valid", 32'(b_if.out_valid), 32'h0);
    cyc();
    b_if.in_valid = 1'b1; b_if.in_sel = 4'd9; b_if.in_data = 8'hC3;
    cyc();
    b_if.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_good_valid", 32'(b_if.out_valid), 32'h200);
    chk("t5_good_data", 32'(b_if.out_data), 32'hC3);
    chk("t5_good_no_err", 32'(b_if.sel_err), 32'h0);
    cyc();

    // Asynchronous reset with a word stalled on channel 4.
    a_if.in_valid = 1'b1; a_if.in_sel = 4'd4; a_if.in_data = 8'h44; a_if.out_ready = '0;
    cyc();
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_held", 32'(a_if.out_valid), 32'h0010);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(a_if.out_valid), 32'h0);
    chk("t6_async_data", 32'(a_if.out_data), 32'h0);
    chk("t6_async_err_cnt", 32'(b_if.err_cnt), 32'h0);
    cyc();
    rst_n = 1'b1;
    a_if.out_ready = '1;
    @(negedge clk);
    chk("t6_after_release", 32'(a_if.out_valid), 32'h0);
    cyc();

    // Random traffic with random per-channel backpressure.
    for (int i = 0; i < 3000; i++) begin
      a_if.in_valid = ($urandom_range(0, 3) != 0);
      a_if.in_sel   = 4'($urandom_range(0, 15));
      a_if.in_data  = 8'($urandom);
      for (int k = 0; k < 16; k++) a_if.out_ready[k] = ($urandom_range(0, 9) < 7);
      cyc();
    end
    a_if.in_valid = 1'b0;
    a_if.out_ready = '1;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
